memory_bus_slave: RTL

//   Memory-side responder for the as_n/wr_n/ack_n bus driven by the write/read request state machine.

---
 rtl/memory_bus_slave.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/memory_bus_slave.sv
// memory_bus_slave: as_n/wr_n/ack_n bus responder with wait states
// backed by an internal RAM; one request in flight at a time.
module memory_bus_slave #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 16,
  parameter int MEM_DEPTH   = 200,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  as_n,
  input  logic                  wr_n,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  ack_n,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  err_n,
  output logic                  busy
);

  localparam int IW =
    (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [3:0] WS = WAIT_STATES[3:0];
  localparam logic [ADDR_WIDTH:0] DEPTH =
    MEM_DEPTH[ADDR_WIDTH:0];

  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_ws_err
    $error("WAIT_STATES must be within 0..15");
  end

  if (MEM_DEPTH < 1 || MEM_DEPTH > (1 << ADDR_WIDTH))
  begin : g_depth_err
    $error("MEM_DEPTH must be within 1..2**ADDR_WIDTH");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [3:0]            r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_wr_n;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_ack_n;
  logic                  r_err_n;
  logic                  r_busy;
  logic [DATA_WIDTH-1:0] r_rd_data;

  logic [DATA_WIDTH-1:0] r_mem [0:MEM_DEPTH-1];

  logic          w_capture;
  logic          w_abort;
  logic          w_enter_ack;
  logic          w_release;
  logic          w_mapped;
  logic          w_ram_we;
  logic [IW-1:0] w_idx;

  // Only the captured address is ever decoded.
  assign w_mapped = ({1'b0, r_addr} < DEPTH);
  assign w_idx    = r_addr[IW-1:0];
  assign w_ram_we = w_enter_ack & w_mapped & ~r_wr_n;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and single-cycle event strobes.
  // A zero wait count still passes through WAIT for
  // one edge so capture-to-ack is WAIT_STATES+1.
  always_comb begin
    w_next      = r_state;
    w_capture   = 1'b0;
    w_abort     = 1'b0;
    w_enter_ack = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!as_n) begin
          w_capture = 1'b1;
          w_next    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (as_n) begin
          w_abort = 1'b1;
          w_next  = S_IDLE;
        end else if (r_cnt == 4'd0) begin
          w_enter_ack = 1'b1;
          w_next      = S_ACK;
        end
      end
      S_ACK: begin
        if (as_n) begin
          w_release = 1'b1;
          w_next    = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Request capture; inputs are ignored while busy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr  <= '0;
      r_wr_n  <= 1'b1;
      r_wdata <= '0;
    end else if (w_capture) begin
      r_addr  <= addr;
      r_wr_n  <= wr_n;
      r_wdata <= wr_data;
    end
  end

  // Wait-state down-counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= 4'd0;
    end else if (w_capture) begin
      r_cnt <= WS;
    end else if (w_abort || w_release) begin
      r_cnt <= 4'd0;
    end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // Handshake and status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ack_n <= 1'b1;
      r_err_n <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      if (w_capture) begin
        r_busy <= 1'b1;
      end
      if (w_abort) begin
        r_busy <= 1'b0;
      end
      if (w_enter_ack) begin
        r_ack_n <= 1'b0;
        r_err_n <= w_mapped;
      end
      if (w_release) begin
        r_ack_n <= 1'b1;
        r_err_n <= 1'b1;
        r_busy  <= 1'b0;
      end
    end
  end

  // Read data loads on ACK entry and holds afterwards.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_data <= '0;
    end else if (w_enter_ack) begin
      if (!w_mapped) begin
        r_rd_data <= '0;
      end else if (r_wr_n) begin
        r_rd_data <= r_mem[w_idx];
      end
    end
  end

  // RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      r_mem[w_idx] <= r_wdata;
    end
  end

  assign ack_n   = r_ack_n;
  assign err_n   = r_err_n;
  assign busy    = r_busy;
  assign rd_data = r_rd_data;

endmodule
